// File: rtl/mem_req_scheduler_if.sv
// Engine-side bus of the request scheduler: one transaction at a time,
// start/done pulses plus a busy level from the byte-serial memory engine.
interface mem_req_scheduler_if #(
  parameter int AW = 32
) ();
  logic          eng_start;
  logic          eng_we;
  logic [2:0]    eng_len;
  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_wdata;
  logic          eng_busy;
  logic          eng_done;
  logic [31:0]   eng_rdata;

  // Scheduler side issues transactions.
  modport master (
    output eng_start, eng_we, eng_len, eng_addr, eng_wdata,
    input  eng_busy, eng_done, eng_rdata
  );

  // Engine side executes them.
  modport slave (
    input  eng_start, eng_we, eng_len, eng_addr, eng_wdata,
    output eng_busy, eng_done, eng_rdata
  );
endinterface

// File: rtl/mem_req_scheduler.sv
// Request scheduler between the IF/MEM pipeline stages and the byte-serial
// memory engine. Load/store has priority; a starvation counter forces a
// fetch through after STARVE_MAX consecutive load/store wins. A flush drops
// the response of an in-flight fetch while the engine finishes it.
module mem_req_scheduler #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [AW-1:0]         if_addr,
  output logic                  if_gnt,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic                  ls_sext,
  input  logic [AW-1:0]         ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  mem_req_scheduler_if.master   eng,
  output logic                  sched_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_LS} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state, state_next;
  owner_t        owner;
  logic          kill;
  logic [3:0]    starve_cnt;
  logic          r_we, r_sext;
  logic [1:0]    r_size;
  logic [31:0]   resp_q;
  logic          eng_start_q, eng_we_q;
  logic [2:0]    eng_len_q;
  logic [AW-1:0] eng_addr_q;
  logic [31:0]   eng_wdata_q;
  logic          issue, pick_fetch;
  logic          fetch_elig, starve_at_max;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                              input logic sext, input logic we);
    if (we) return 32'd0;
    case (size)
      2'd0:    return {{24{sext & d[7]}}, d[7:0]};
      2'd1:    return {{16{sext & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign fetch_elig    = if_req & ~flush;
  assign starve_at_max = (starve_cnt == STARVE_LIM);
  assign sched_busy    = (state != IDLE);

  assign eng.eng_start = eng_start_q;
  assign eng.eng_we    = eng_we_q;
  assign eng.eng_len   = eng_len_q;
  assign eng.eng_addr  = eng_addr_q;
  assign eng.eng_wdata = eng_wdata_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, arbitration and response outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    issue      = 1'b0;
    pick_fetch = 1'b0;
    if_done    = 1'b0;
    if_rdata   = 32'd0;
    ls_done    = 1'b0;
    ls_rdata   = 32'd0;
    case (state)
      IDLE: begin
        if (!eng.eng_busy && (ls_req || fetch_elig)) begin
          issue      = 1'b1;
          pick_fetch = fetch_elig && (!ls_req || starve_at_max);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (eng.eng_done) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (owner == OWN_LS) begin
          ls_done  = 1'b1;
          ls_rdata = resp_q;
        end else if (!kill) begin
          if_done  = 1'b1;
          if_rdata = resp_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue registers, starvation counter, kill flag and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_start_q <= 1'b0;
      eng_we_q    <= 1'b0;
      eng_len_q   <= 3'd0;
      eng_addr_q  <= '0;
      eng_wdata_q <= 32'd0;
      if_gnt      <= 1'b0;
      ls_gnt      <= 1'b0;
      owner       <= OWN_FETCH;
      kill        <= 1'b0;
      starve_cnt  <= 4'd0;
      r_we        <= 1'b0;
      r_sext      <= 1'b0;
      r_size      <= 2'd0;
      resp_q      <= 32'd0;
    end else begin
      eng_start_q <= issue;
      if_gnt      <= issue & pick_fetch;
      ls_gnt      <= issue & ~pick_fetch;
      if (issue) begin
        if (pick_fetch) begin
          owner       <= OWN_FETCH;
          eng_we_q    <= 1'b0;
          eng_len_q   <= 3'd4;
          eng_addr_q  <= if_addr;
          eng_wdata_q <= 32'd0;
          starve_cnt  <= 4'd0;
        end else begin
          owner       <= OWN_LS;
          eng_we_q    <= ls_we;
          eng_len_q   <= size_to_len(ls_size);
          eng_addr_q  <= ls_addr;
          eng_wdata_q <= ls_we ? ls_wdata : 32'd0;
          r_we        <= ls_we;
          r_sext      <= ls_sext;
          r_size      <= ls_size;
          if (!if_req)             starve_cnt <= 4'd0;
          else if (!starve_at_max) starve_cnt <= starve_cnt + 4'd1;
        end
      end
      // Flush anywhere in the wait window (including the start cycle) drops
      // a fetch response; the engine transaction itself still completes.
      if (state == WAIT && owner == OWN_FETCH && flush) kill <= 1'b1;
      else if (state == RESP)                          kill <= 1'b0;
      if (state == WAIT && eng.eng_done)
        resp_q <= (owner == OWN_FETCH) ? eng.eng_rdata
                                       : extend_load(eng.eng_rdata, r_size, r_sext, r_we);
    end
  end

endmodule
